maze_player_ctrl: RTL and testbench

// Player-movement and overlay stage directly downstream of the maze pixel generator.

---
 rtl/maze_player_ctrl.sv | 176 +++++++++++++++++
 tb/tb_maze_player_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/maze_player_ctrl.sv
// Player-movement and sprite-overlay stage behind the maze pixel generator.
// Optional goal flashing is enabled by defining GOAL_FLASH_EN.
module maze_player_ctrl #(
  parameter int          SCREEN_W     = 96,
  parameter int          SCREEN_H     = 64,
  parameter int          PLAYER_SIZE  = 6,
  parameter int          X_START      = 4,
  parameter int          Y_START      = 4,
  parameter int          GOAL_Y       = 58,
  parameter logic [15:0] WALL_COLOR   = 16'hFFFF,
  parameter logic [15:0] PLAYER_COLOR = 16'hF800,
  parameter int          FLASH_FRAMES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_begin,
  input  logic [12:0] pixel_index,
  input  logic [15:0] maze_data,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [15:0] pixel_data,
  output logic [6:0]  player_x,
  output logic [5:0]  player_y,
  output logic        move_busy,
  output logic        at_goal,
  output logic [2:0]  fsm_state
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WAIT_FRAME = 3'd1;
  localparam logic [2:0] SCAN       = 3'd2;
  localparam logic [2:0] COMMIT     = 3'd3;
  localparam logic [2:0] WIN        = 3'd4;

  logic [2:0]  state;
  logic [12:0] idx_d;
  logic [6:0]  pix_x;
  logic [5:0]  pix_y;
  logic [6:0]  cand_x;
  logic [5:0]  cand_y;
  logic        hit;
  logic [6:0]  next_x;
  logic [5:0]  next_y;
  logic        move_req;
  logic        move_ok;
  logic [5:0]  commit_y;
  logic        in_player;
  logic        in_cand;
  logic [15:0] sprite_color;

  // idx_d is one cycle behind pixel_index, so it lines up with maze_data.
  assign pix_x = 7'(idx_d % 13'(SCREEN_W));
  assign pix_y = 6'(idx_d / 13'(SCREEN_W));

  function automatic logic in_rect(input logic [6:0] x, input logic [5:0] y,
                                   input logic [6:0] rx, input logic [5:0] ry);
    logic in_x;
    logic in_y;
    in_x = ({1'b0, x} >= {1'b0, rx}) && ({1'b0, x} < ({1'b0, rx} + 8'(PLAYER_SIZE)));
    in_y = ({1'b0, y} >= {1'b0, ry}) && ({1'b0, y} < ({1'b0, ry} + 7'(PLAYER_SIZE)));
    return in_x && in_y;
  endfunction

  assign in_player = in_rect(pix_x, pix_y, player_x, player_y);
  assign in_cand   = in_rect(pix_x, pix_y, cand_x, cand_y);

  // One-pixel step candidate; priority up > down > left > right, bounds-checked.
  always_comb begin
    next_x   = player_x;
    next_y   = player_y;
    move_req = 1'b0;
    move_ok  = 1'b0;
    if (btn_up) begin
      move_req = 1'b1;
      move_ok  = (player_y != 6'd0);
      next_y   = player_y - 6'd1;
    end else if (btn_down) begin
      move_req = 1'b1;
      move_ok  = (({1'b0, player_y} + 7'(PLAYER_SIZE)) < 7'(SCREEN_H));
      next_y   = player_y + 6'd1;
    end else if (btn_left) begin
      move_req = 1'b1;
      move_ok  = (player_x != 7'd0);
      next_x   = player_x - 7'd1;
    end else if (btn_right) begin
      move_req = 1'b1;
      move_ok  = (({1'b0, player_x} + 8'(PLAYER_SIZE)) < 8'(SCREEN_W));
      next_x   = player_x + 7'd1;
    end
  end

  assign commit_y = hit ? player_y : cand_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      player_x <= 7'(X_START);
      player_y <= 6'(Y_START);
      cand_x   <= 7'(X_START);
      cand_y   <= 6'(Y_START);
      hit      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (move_req && move_ok) begin
            cand_x <= next_x;
            cand_y <= next_y;
            hit    <= 1'b0;
            state  <= WAIT_FRAME;
          end
        end
        WAIT_FRAME: begin
          if (frame_begin) state <= SCAN;
        end
        SCAN: begin
          // The frame_begin cycle still carries the last pixel of the frame.
          if (in_cand && (maze_data == WALL_COLOR)) hit <= 1'b1;
          if (frame_begin) state <= COMMIT;
        end
        COMMIT: begin
          if (!hit) begin
            player_x <= cand_x;
            player_y <= cand_y;
          end
          state <= (commit_y >= 6'(GOAL_Y)) ? WIN : IDLE;
        end
        WIN: state <= WIN;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GOAL_FLASH_EN
  logic [7:0] flash_cnt;
  logic       flash_phase;

  // Outside WIN the counter is held at zero, so it restarts on every WIN entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_cnt   <= 8'd0;
      flash_phase <= 1'b0;
    end else if (state != WIN) begin
      flash_cnt   <= 8'd0;
      flash_phase <= 1'b0;
    end else if (frame_begin) begin
      if (flash_cnt == 8'(FLASH_FRAMES - 1)) begin
        flash_cnt   <= 8'd0;
        flash_phase <= ~flash_phase;
      end else begin
        flash_cnt <= flash_cnt + 8'd1;
      end
    end
  end

  assign sprite_color = flash_phase ? ~PLAYER_COLOR : PLAYER_COLOR;
`else
  assign sprite_color = PLAYER_COLOR;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_d      <= 13'd0;
      pixel_data <= 16'd0;
    end else begin
      idx_d      <= pixel_index;
      pixel_data <= in_player ? sprite_color : maze_data;
    end
  end

  assign move_busy = (state == WAIT_FRAME) || (state == SCAN) || (state == COMMIT);
  assign at_goal   = (state == WIN);
  assign fsm_state = state;

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Directed bench for maze_player_ctrl: pixel overlay, moves, walls, bounds, goal, reset.
// The upstream maze generator is modelled by maze_fn with one cycle of latency.
module tb_maze_player_ctrl;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_SCAN   = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_WIN    = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_begin;
  logic [12:0] pixel_index;
  logic [15:0] maze_data;
  logic        btn_up, btn_down, btn_left, btn_right;
  logic [15:0] pixel_data;
  logic [6:0]  player_x;
  logic [5:0]  player_y;
  logic        move_busy;
  logic        at_goal;
  logic [2:0]  fsm_state;

  int   checks = 0;
  int   errors = 0;
  logic wall_en = 1'b0;
  logic saw_busy;

  maze_player_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_begin (frame_begin),
    .pixel_index (pixel_index),
    .maze_data   (maze_data),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .pixel_data  (pixel_data),
    .player_x    (player_x),
    .player_y    (player_y),
    .move_busy   (move_busy),
    .at_goal     (at_goal),
    .fsm_state   (fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Maze model: vertical wall at x=10, rows 4..9 when wall_en is set
  function automatic logic [15:0] maze_fn(input logic [12:0] idx);
    int x;
    int y;
    x = int'(idx) % 96;
    y = int'(idx) / 96;
    if (wall_en && (x == 10) && (y >= 4) && (y <= 9)) return 16'hFFFF;
    return {3'b000, idx} ^ 16'h0A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drivers: maze_data follows the index presented on the previous cycle
  task automatic tick(input logic [12:0] idx, input logic fb);
    maze_data   = maze_fn(pixel_index);
    pixel_index = idx;
    frame_begin = fb;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic u, input logic d, input logic l, input logic r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    tick(13'd5000, 1'b0);
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
  endtask

  task automatic do_frame(input int n);
    tick(13'd0, 1'b1);
    for (int i = 1; i < n; i++) tick(13'(i), 1'b0);
  endtask

  task automatic do_move(input logic u, input logic d, input logic l, input logic r);
    press(u, d, l, r);
    do_frame(8);
    tick(13'd0, 1'b1);
    tick(13'd1, 1'b0);
  endtask

  task automatic check_pixel(input string tag, input logic [12:0] idx, input logic [15:0] exp);
    tick(idx, 1'b0);
    tick(13'd0, 1'b0);
    check(tag, pixel_data, exp);
  endtask

  initial begin
    rst_n = 1'b0; frame_begin = 1'b0; pixel_index = 13'd0; maze_data = 16'd0;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    tick(13'd0, 1'b0);
    tick(13'd0, 1'b0);
    check("rst_pixel", pixel_data, 16'h0000);
    check("rst_x", player_x, 7'd4);
    check("rst_y", player_y, 6'd4);
    check("rst_busy", move_busy, 1'b0);
    check("rst_goal", at_goal, 1'b0);
    check("rst_state", fsm_state, S_IDLE);
    rst_n = 1'b1;
    tick(13'd0, 1'b0);

    // Pixel overlay at (4,4) and pass-through elsewhere
    check_pixel("pix_sprite_tl", 13'd388, 16'hF800);
    check_pixel("pix_idx0", 13'd0, 16'h0A5A);
    check_pixel("pix_right_edge_out", 13'd394, 16'h0BD0);
    check_pixel("pix_sprite_br", 13'd873, 16'hF800);
    check_pixel("pix_below_out", 13'd964, 16'h099E);

    // Wall at x=10 blocks a right move from x=4
    wall_en = 1'b1;
    check_pixel("pix_wall", 13'd394, 16'hFFFF);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    check("wall_busy", move_busy, 1'b1);
    check("wall_state_wait", fsm_state, S_WAIT);
    do_frame(1536);
    check("wall_state_scan", fsm_state, S_SCAN);
    tick(13'd0, 1'b1);
    check("wall_state_commit", fsm_state, S_COMMIT);
    tick(13'd1, 1'b0);
    check("wall_x", player_x, 7'd4);
    check("wall_busy_done", move_busy, 1'b0);
    wall_en = 1'b0;

    // Free right move commits the cycle after the second frame_begin
    press(1'b0, 1'b0, 1'b0, 1'b1);
    check("right_busy", move_busy, 1'b1);
    do_frame(16);
    check("right_x_scan", player_x, 7'd4);
    tick(13'd0, 1'b1);
    check("right_x_commit_cycle", player_x, 7'd4);
    tick(13'd1, 1'b0);
    check("right_x", player_x, 7'd5);
    check("right_busy_done", move_busy, 1'b0);
    check_pixel("pix_moved_old", 13'd388, 16'h0BDE);
    check_pixel("pix_moved_new", 13'd394, 16'hF800);

    // Walk to x=0, then a left press is rejected without a busy cycle
    for (int i = 0; i < 5; i++) do_move(1'b0, 1'b0, 1'b1, 1'b0);
    check("left_x0", player_x, 7'd0);
    saw_busy = 1'b0;
    press(1'b0, 1'b0, 1'b1, 1'b0);
    saw_busy = saw_busy | move_busy;
    check("left_reject_state", fsm_state, S_IDLE);
    for (int i = 0; i < 3; i++) begin
      do_frame(4);
      saw_busy = saw_busy | move_busy;
    end
    check("left_reject_busy", saw_busy, 1'b0);
    check("left_reject_x", player_x, 7'd0);

    // Up wins over left; a down press during SCAN is dropped
    do_move(1'b1, 1'b0, 1'b1, 1'b0);
    check("prio_x", player_x, 7'd0);
    check("prio_y", player_y, 6'd3);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    do_frame(4);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    check("drop_state_scan", fsm_state, S_SCAN);
    tick(13'd0, 1'b1);
    tick(13'd1, 1'b0);
    check("drop_y", player_y, 6'd2);
    do_frame(4);
    do_frame(4);
    check("drop_not_queued_busy", move_busy, 1'b0);
    check("drop_not_queued_y", player_y, 6'd2);

    // Walk down to the goal row
    for (int i = 0; i < 55; i++) do_move(1'b0, 1'b1, 1'b0, 1'b0);
    check("goal_y57", player_y, 6'd57);
    check("goal_not_yet", at_goal, 1'b0);
    do_move(1'b0, 1'b1, 1'b0, 1'b0);
    check("goal_y58", player_y, 6'd58);
    check("goal_at_goal", at_goal, 1'b1);
    check("goal_state", fsm_state, S_WIN);
    check("goal_busy", move_busy, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    do_frame(4);
    do_frame(4);
    check("win_ignore_busy", move_busy, 1'b0);
    check("win_ignore_y", player_y, 6'd58);
    check("win_ignore_x", player_x, 7'd0);
    check("win_hold", at_goal, 1'b1);

    // Reset leaves WIN; reset mid-SCAN discards the pending move
    rst_n = 1'b0;
    tick(13'd0, 1'b0);
    rst_n = 1'b1;
    check("win_rst_goal", at_goal, 1'b0);
    check("win_rst_y", player_y, 6'd4);
    do_move(1'b0, 1'b0, 1'b0, 1'b1);
    check("pre_rst_x", player_x, 7'd5);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    do_frame(8);
    check("mid_scan_state", fsm_state, S_SCAN);
    rst_n = 1'b0;
    #1;
    check("mid_rst_x", player_x, 7'd4);
    check("mid_rst_y", player_y, 6'd4);
    check("mid_rst_busy", move_busy, 1'b0);
    check("mid_rst_state", fsm_state, S_IDLE);
    tick(13'd0, 1'b0);
    rst_n = 1'b1;
    do_frame(4);
    do_frame(4);
    tick(13'd1, 1'b0);
    check("post_rst_x", player_x, 7'd4);
    check("post_rst_busy", move_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
